po_cko_pad_array: RTL and testbench
===================================

Name: po_cko_pad_array

Overview:
- Parametrised successor of the single-channel po_cko pad tile: drives NUM_CH fabric-to-pad outputs from one tile.
- Each channel has a runtime-selectable mode: combinational bypass, registered, programmable clock-divider output, or forced low.
- Mode and divide configuration is loaded through a serial config chain with a shadow/update stage, so reconfiguration is glitch-free.
- The output data flops also form a scan chain (SE0/sc_in/sc_out), as in the single-channel tile.

Parameters:
- NUM_CH, 4, number of pad channels (1..16).
- DIV_W, 4, divider terminal-count width per channel.
- CFG_W, NUM_CH*(2+DIV_W) (+NUM_CH with OE feature), derived config chain length; not overridable.

Ports:
- po_cko_pad_clk  input  1  tile clock, rising edge.
- po_cko_pad_reset  input  1  synchronous, active-high reset.
- SE0  input  1  scan enable for the data-flop chain.
- po_cko_pad_sc_in  input  1  scan chain input.
- po_cko_pad_sc_out  output  1  scan chain output (last channel flop).
- po_cko_pad_f2a_i  input  NUM_CH  fabric data, one bit per channel.
- cfg_shift_en  input  1  shift config chain one bit per cycle.
- cfg_in  input  1  config serial input.
- cfg_update  input  1  one-cycle pulse: copy shift chain into active config.
- cfg_out  output  1  config serial output (chain MSB).
- gfpga_pad_poutput_F2A  output  NUM_CH  pad outputs.

Behaviour:
- Per-channel config fields, ch0 at the LSBs: mode[1:0], then div[DIV_W-1:0]. Fields for ch k occupy bits [k*(2+DIV_W) +: 2+DIV_W].
- Channel modes:
  - mode 0, bypass: pad = f2a_i[k], combinational.
  - mode 1, registered: pad = q[k], where q[k] <= f2a_i[k] each cycle.
  - mode 2, divided clock: a DIV_W counter cnt[k] counts 0..div. On cnt==div, cnt returns to 0 and q[k] toggles. Pad = q[k], with period 2*(div+1) cycles; div=0 gives clk/2.
  - mode 3, forced low: pad = 0, and q[k] holds.
- Config shift: when cfg_shift_en=1, shift_reg <= {shift_reg[CFG_W-2:0], cfg_in}. cfg_out = shift_reg[CFG_W-1]. Active config is unchanged while shifting.
- Config update: when cfg_update=1, active_cfg <= shift_reg. In the same cycle every channel's cnt and q clear to 0. The new mode takes effect from the next cycle.
- Simultaneous cfg_shift_en and cfg_update: the update captures the pre-shift shift_reg and the shift also occurs.
- Scan: while SE0=1, q forms a chain sc_in -> q[0] -> ... -> q[NUM_CH-1] -> sc_out. In that cycle the functional capture, counters and toggling are suppressed. Scan has priority over cfg_update for q and cnt; the active config still updates.
- po_cko_pad_sc_out = q[NUM_CH-1], registered.
- Reset (synchronous, priority over all):
  - shift_reg, active_cfg, cnt and q clear to 0.
  - All channels are therefore in mode 0, so pad follows f2a_i combinationally.
  - cfg_out = 0 and sc_out = 0 after the reset edge.
- Reset asserted mid-shift or mid-divide discards the partial state. No pending update survives reset.
- Latency:
  - mode 0: zero cycles.
  - mode 1: one cycle.
  - mode 2: the first toggle occurs div+1 cycles after update or reset release.

Optional Feature:
- Macro: PO_CKO_PAD_OE_EN.
- Defined:
  - Adds output gfpga_pad_oe[NUM_CH] and one oe config bit per channel, placed above div. CFG_W grows by NUM_CH.
  - gfpga_pad_oe[k] = active oe bit, registered through active_cfg, reset 0.
  - Forced-low mode 3 additionally drives oe[k]=0 regardless of the bit.
- Undefined: no oe port or config bits, and CFG_W = NUM_CH*(2+DIV_W).

Test Plan:
- Reset, then f2a_i=4'b1010 -> pad=4'b1010 the same cycle; cfg_out=0, sc_out=0.
- Shift 24 bits setting ch1 mode 1 (others 0), pulse cfg_update, then drive f2a_i[1] 0->1 at cycle t -> pad[1] rises at t+1; pad[0] follows f2a_i[0] combinationally.
- ch2 mode 2, div=2 -> pad[2] toggles every 3 cycles, first toggle 3 cycles after update, period 6.
- SE0=1 for 4 cycles with sc_in=1,0,1,1 while ch0..3 in mode 1 -> sc_out shows 1 on cycle 4. During scan, the ch2 divider does not advance.
- Assert reset mid-shift (12 bits shifted) and during divide -> next cycle all q, cnt and config are 0; pad=f2a_i; cfg_out=0.
- With PO_CKO_PAD_OE_EN: set ch3 oe=1, mode 3 -> oe[3]=0 and pad[3]=0. Change to mode 1 -> oe[3]=1 from the cycle after update.

Source files
------------

// File: rtl/po_cko_pad_array.sv
// Purpose: NUM_CH pad-output channels (bypass/registered/divided clock/forced low), serial config with shadow update, scan on q. Optional OE via PO_CKO_PAD_OE_EN.
// Latency: bypass 0 cycles, registered 1 cycle, divider first toggle div+1 cycles after update/reset; config active the cycle after cfg_update.
// Backpressure: none, free-running; scan (SE0) freezes functional capture and dividers, the config shift chain runs independently.
module po_cko_pad_array #(
   parameter int NUM_CH = 4,
   parameter int DIV_W  = 4
) (
   input  logic              po_cko_pad_clk,
   input  logic              po_cko_pad_reset,
   input  logic              SE0,
   input  logic              po_cko_pad_sc_in,
   output logic              po_cko_pad_sc_out,
   input  logic [NUM_CH-1:0] po_cko_pad_f2a_i,
   input  logic              cfg_shift_en,
   input  logic              cfg_in,
   input  logic              cfg_update,
   output logic              cfg_out,
`ifdef PO_CKO_PAD_OE_EN
   output logic [NUM_CH-1:0] gfpga_pad_oe,
`endif
   output logic [NUM_CH-1:0] gfpga_pad_poutput_F2A
);

`ifdef PO_CKO_PAD_OE_EN
   localparam int OE_W = 1;
`else
   localparam int OE_W = 0;
`endif
   // per-channel field: {oe (optional), div, mode}, channel 0 at the LSBs
   localparam int FLD_W = 2 + DIV_W + OE_W;
   localparam int CFG_W = NUM_CH * FLD_W;

   localparam logic [1:0] MODE_BYP = 2'd0;
   localparam logic [1:0] MODE_REG = 2'd1;
   localparam logic [1:0] MODE_DIV = 2'd2;
   localparam logic [1:0] MODE_LOW = 2'd3;

   logic [CFG_W-1:0]  shift_reg;
   logic [CFG_W-1:0]  active_cfg;
   logic [NUM_CH-1:0] q;
   logic [DIV_W-1:0]  cnt  [NUM_CH];
   logic [1:0]        mode [NUM_CH];
   logic [DIV_W-1:0]  div  [NUM_CH];

   // slice the active configuration into per-channel fields
   for (genvar g = 0; g < NUM_CH; g++) begin : g_dec
      assign mode[g] = active_cfg[g*FLD_W +: 2];
      assign div[g]  = active_cfg[g*FLD_W+2 +: DIV_W];
   end

   // config chain: shift and update are independent; update sees the pre-shift value
   always_ff @(posedge po_cko_pad_clk) begin
      if (po_cko_pad_reset) begin
         shift_reg  <= '0;
         active_cfg <= '0;
      end else begin
         if (cfg_shift_en)
            shift_reg <= {shift_reg[CFG_W-2:0], cfg_in};
         if (cfg_update)
            active_cfg <= shift_reg;
      end
   end

   assign cfg_out = shift_reg[CFG_W-1];

   // data flops and dividers: scan beats update, update restarts every channel
   always_ff @(posedge po_cko_pad_clk) begin
      if (po_cko_pad_reset) begin
         q <= '0;
         for (int k = 0; k < NUM_CH; k++)
            cnt[k] <= '0;
      end else if (SE0) begin
         q[0] <= po_cko_pad_sc_in;
         for (int k = 1; k < NUM_CH; k++)
            q[k] <= q[k-1];
      end else if (cfg_update) begin
         q <= '0;
         for (int k = 0; k < NUM_CH; k++)
            cnt[k] <= '0;
      end else begin
         for (int k = 0; k < NUM_CH; k++) begin
            case (mode[k])
               MODE_REG: q[k] <= po_cko_pad_f2a_i[k];
               MODE_DIV: begin
                  if (cnt[k] == div[k]) begin
                     cnt[k] <= '0;
                     q[k]   <= ~q[k];
                  end else begin
                     cnt[k] <= cnt[k] + DIV_W'(1);
                  end
               end
               default: ; // bypass and forced-low leave q and cnt untouched
            endcase
         end
      end
   end

   assign po_cko_pad_sc_out = q[NUM_CH-1];

   // pad mux per channel
   always_comb begin
      gfpga_pad_poutput_F2A = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         case (mode[k])
            MODE_BYP: gfpga_pad_poutput_F2A[k] = po_cko_pad_f2a_i[k];
            MODE_REG,
            MODE_DIV: gfpga_pad_poutput_F2A[k] = q[k];
            default:  gfpga_pad_poutput_F2A[k] = 1'b0;
         endcase
      end
   end

`ifdef PO_CKO_PAD_OE_EN
   // output enable straight from active config, forced off in forced-low mode
   always_comb begin
      gfpga_pad_oe = '0;
      for (int k = 0; k < NUM_CH; k++)
         gfpga_pad_oe[k] = active_cfg[k*FLD_W+2+DIV_W] && (mode[k] != MODE_LOW);
   end
`endif

endmodule

// File: tb/tb_po_cko_pad_array.sv
// Directed bench for po_cko_pad_array (NUM_CH=4, DIV_W=4).
// Inputs are driven 1 time unit after the rising edge and outputs checked there.
// Optional OE checks are compiled only with PO_CKO_PAD_OE_EN.
module tb_po_cko_pad_array;
   localparam int NUM_CH = 4;
   localparam int DIV_W  = 4;
`ifdef PO_CKO_PAD_OE_EN
   localparam int FLD_W = 2 + DIV_W + 1;
`else
   localparam int FLD_W = 2 + DIV_W;
`endif
   localparam int CFG_W = NUM_CH * FLD_W;

   logic              clk;
   logic              rst;
   logic              se0;
   logic              sc_in;
   logic              sc_out;
   logic [NUM_CH-1:0] f2a;
   logic              shift_en;
   logic              cin;
   logic              upd;
   logic              cout;
   logic [NUM_CH-1:0] pad;
`ifdef PO_CKO_PAD_OE_EN
   logic [NUM_CH-1:0] oe;
`endif

   int n_vec = 0;
   int n_err = 0;

   po_cko_pad_array #(.NUM_CH(NUM_CH), .DIV_W(DIV_W)) dut (
      .po_cko_pad_clk        (clk),
      .po_cko_pad_reset      (rst),
      .SE0                   (se0),
      .po_cko_pad_sc_in      (sc_in),
      .po_cko_pad_sc_out     (sc_out),
      .po_cko_pad_f2a_i      (f2a),
      .cfg_shift_en          (shift_en),
      .cfg_in                (cin),
      .cfg_update            (upd),
      .cfg_out               (cout),
`ifdef PO_CKO_PAD_OE_EN
      .gfpga_pad_oe          (oe),
`endif
      .gfpga_pad_poutput_F2A (pad)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk4(input string tag, input logic [NUM_CH-1:0] obs, input logic [NUM_CH-1:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   function automatic logic [CFG_W-1:0] fld(input int ch, input int mode, input int div);
      logic [CFG_W-1:0] v;
      v = '0;
      v[ch*FLD_W +: 2]       = mode[1:0];
      v[ch*FLD_W+2 +: DIV_W] = div[DIV_W-1:0];
      return v;
   endfunction

   task automatic shift_cfg(input logic [CFG_W-1:0] v);
      for (int i = CFG_W-1; i >= 0; i--) begin
         cin      = v[i];
         shift_en = 1'b1;
         tick();
      end
      shift_en = 1'b0;
      cin      = 1'b0;
   endtask

   task automatic pulse_update();
      upd = 1'b1;
      tick();
      upd = 1'b0;
   endtask

   initial begin
      logic [CFG_W-1:0]  v1;
      logic [CFG_W-1:0]  v2;
      logic [NUM_CH-1:0] e;
      logic [NUM_CH-1:0] sh;
      logic [3:0]        scp;

      rst = 1'b1; se0 = 1'b0; sc_in = 1'b0; f2a = '0;
      shift_en = 1'b0; cin = 1'b0; upd = 1'b0;
      tick();
      tick();

      // reset state: all bypass
      chk1("rst_cfg_out", cout, 1'b0);
      chk1("rst_sc_out", sc_out, 1'b0);
`ifdef PO_CKO_PAD_OE_EN
      chk4("rst_oe", oe, 4'b0000);
`endif
      rst = 1'b0;
      f2a = 4'b1010;
      #1;
      chk4("rst_bypass", pad, 4'b1010);

      // ch1 registered, others bypass
      v1 = fld(1, 1, 0);
      shift_cfg(v1);
      chk1("v1_cfg_out", cout, v1[CFG_W-1]);
      f2a = 4'b0101;
      #1;
      chk4("shift_no_effect", pad, 4'b0101);
      f2a = 4'b0000;
      pulse_update();
      tick();
      f2a = 4'b0011;
      #1;
      chk4("reg_before_edge", pad, 4'b0001);
      tick();
      chk4("reg_after_edge", pad, 4'b0011);
      f2a = 4'b0001;
      #1;
      chk4("reg_hold", pad, 4'b0011);
      tick();
      chk4("reg_fall", pad, 4'b0001);

      // shift and update in the same cycle: update takes the pre-shift chain
      cin = 1'b1; shift_en = 1'b1; upd = 1'b1;
      tick();
      cin = 1'b0; shift_en = 1'b0; upd = 1'b0;
      f2a = 4'b0001;
      #1;
      chk4("simul_bypass", pad, 4'b0001);
      f2a = 4'b0010;
      tick();
      chk4("simul_reg", pad, 4'b0010);

      // ch0/1/3 registered, ch2 divider div=2, chain MSB forced to 1
      f2a = 4'b0000;
      v2 = fld(0, 1, 0) | fld(1, 1, 0) | fld(2, 2, 2) | fld(3, 1, 0);
      v2[CFG_W-1] = 1'b1;
      shift_cfg(v2);
      chk1("v2_cfg_out", cout, 1'b1);
      pulse_update();
      for (int n = 1; n <= 9; n++) begin
         tick();
         e = '0;
         e[2] = ((n / 3) % 2) == 1;
         chk4($sformatf("div_n%0d", n), pad, e);
      end

      // scan 4 cycles; q before scan is 0100
      sh  = 4'b0100;
      scp = 4'b1101;
      for (int i = 0; i < 4; i++) begin
         sc_in = scp[i];
         se0   = 1'b1;
         tick();
         sh = {sh[2:0], scp[i]};
         chk1($sformatf("scan_out_c%0d", i+1), sc_out, sh[3]);
      end
      chk4("scan_pad", pad, 4'b1011);
      se0 = 1'b0; sc_in = 1'b0;
      // divider restarts from where scan froze it (cnt=0, q2=0)
      for (int t = 1; t <= 3; t++) begin
         tick();
         e = '0;
         e[2] = (t == 3);
         chk4($sformatf("post_scan_t%0d", t), pad, e);
      end

      // reset mid-shift and mid-divide
      cin = 1'b1; shift_en = 1'b1;
      for (int i = 0; i < 12; i++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0; shift_en = 1'b0; cin = 1'b0;
      chk1("midrst_cfg_out", cout, 1'b0);
      chk1("midrst_sc_out", sc_out, 1'b0);
      f2a = 4'b1111;
      #1;
      chk4("midrst_bypass_a", pad, 4'b1111);
      f2a = 4'b0101;
      #1;
      chk4("midrst_bypass_b", pad, 4'b0101);
      pulse_update();
      f2a = 4'b1111;
      #1;
      chk4("midrst_upd_zero", pad, 4'b1111);

`ifdef PO_CKO_PAD_OE_EN
      // ch3 oe=1 with forced low, then registered
      v1 = fld(3, 3, 0);
      v1[3*FLD_W+2+DIV_W] = 1'b1;
      shift_cfg(v1);
      pulse_update();
      chk4("oe_low_oe", oe, 4'b0000);
      chk4("oe_low_pad", pad, 4'b0111);
      v1 = fld(3, 1, 0);
      v1[3*FLD_W+2+DIV_W] = 1'b1;
      shift_cfg(v1);
      chk4("oe_pre_upd", oe, 4'b0000);
      pulse_update();
      chk4("oe_reg_oe", oe, 4'b1000);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
